// File: rtl/decode_pkg.sv
// Shared encodings, opcodes, control bundle and immediate generator for the
// RV32I decode stage.
package decode_pkg;

    // ExtOp: immediate format
    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    // ALUctr
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_COPYB = 4'b1111;

    // Branch
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    // ALUBsrc
    localparam logic [1:0] BSRC_RS2  = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;

    // Opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [2:0] ExtOp;
        logic       RegWr;
        logic       ALUAsrc;
        logic [1:0] ALUBsrc;
        logic [3:0] ALUctr;
        logic [2:0] Branch;
        logic       MemtoReg;
        logic       MemWr;
        logic [2:0] MemOp;
        logic [3:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    // Sign-extended immediate for the given format
    function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [2:0] ext);
        case (ext)
            EXT_U:   return {i[31:12], 12'b0};
            EXT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            EXT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            EXT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/rv32_decode_core.sv
// Combinational RV32I decoder: instruction -> control bundle + immediate.
// Optional macro RV32M_DECODE_EN makes OP/func7=0000001 (M extension) legal.
module rv32_decode_core
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [31:0] imm_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       bad;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    // Opcode decode; any illegal encoding collapses to a NOP with illegal set
    always_comb begin
        c   = '0;
        bad = 1'b0;
        case (opc)
            OPC_LUI: begin
                c.ExtOp = EXT_U; c.RegWr = 1'b1; c.ALUBsrc = BSRC_IMM; c.ALUctr = ALU_COPYB;
            end
            OPC_AUIPC: begin
                c.ExtOp = EXT_U; c.RegWr = 1'b1; c.ALUAsrc = 1'b1; c.ALUBsrc = BSRC_IMM;
                c.ALUctr = ALU_ADD;
            end
            OPC_OPIMM: begin
                c.ExtOp = EXT_I; c.RegWr = 1'b1; c.ALUBsrc = BSRC_IMM; c.ALUctr = {1'b0, f3};
                if (f3 == 3'b001) begin
                    bad = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000) c.ALUctr = ALU_SRA;
                    else if (f7 != 7'b0000000) bad = 1'b1;
                end
            end
            OPC_OP: begin
                c.RegWr = 1'b1; c.ALUBsrc = BSRC_RS2; c.ALUctr = {1'b0, f3};
                case (f7)
                    7'b0000000: ;
                    7'b0100000: begin
                        if (f3 == 3'b000)      c.ALUctr = ALU_SUB;
                        else if (f3 == 3'b101) c.ALUctr = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    7'b0000001: begin
`ifdef RV32M_DECODE_EN
                        c.ALUctr = 4'b0000;
                        c.mdu_op = {1'b1, f3};
`else
                        bad = 1'b1;
`endif
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                c.ExtOp = EXT_J; c.RegWr = 1'b1; c.ALUAsrc = 1'b1; c.ALUBsrc = BSRC_FOUR;
                c.ALUctr = ALU_ADD; c.Branch = BR_JAL;
            end
            OPC_JALR: begin
                c.ExtOp = EXT_I; c.RegWr = 1'b1; c.ALUAsrc = 1'b1; c.ALUBsrc = BSRC_FOUR;
                c.ALUctr = ALU_ADD; c.Branch = BR_JALR;
                bad = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.ExtOp = EXT_B; c.ALUBsrc = BSRC_RS2;
                case (f3)
                    3'b000:  begin c.Branch = BR_EQ; c.ALUctr = ALU_SUB;  end
                    3'b001:  begin c.Branch = BR_NE; c.ALUctr = ALU_SUB;  end
                    3'b100:  begin c.Branch = BR_LT; c.ALUctr = ALU_SLT;  end
                    3'b101:  begin c.Branch = BR_GE; c.ALUctr = ALU_SLT;  end
                    3'b110:  begin c.Branch = BR_LT; c.ALUctr = ALU_SLTU; end
                    3'b111:  begin c.Branch = BR_GE; c.ALUctr = ALU_SLTU; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.ExtOp = EXT_I; c.RegWr = 1'b1; c.ALUBsrc = BSRC_IMM; c.ALUctr = ALU_ADD;
                c.MemtoReg = 1'b1; c.MemOp = f3;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                c.ExtOp = EXT_S; c.ALUBsrc = BSRC_IMM; c.ALUctr = ALU_ADD;
                c.MemWr = 1'b1; c.MemOp = f3;
                bad = (f3 >= 3'b011);
            end
            default: bad = 1'b1;
        endcase
        if (opc[1:0] != 2'b11) bad = 1'b1;
        if (bad) begin
            c         = '0;
            c.illegal = 1'b1;
        end
    end

    assign ctrl_o = c;
    assign imm_o  = c.illegal ? 32'h0 : gen_imm(instr_i, c.ExtOp);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode into a DEPTH-entry
// FIFO toward execute. Optional macro RV32M_DECODE_EN enables M-extension
// decode in rv32_decode_core.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [31:0]            out_imm,
    output logic [2:0]             out_ExtOp,
    output logic                   out_RegWr,
    output logic                   out_ALUAsrc,
    output logic [1:0]             out_ALUBsrc,
    output logic [3:0]             out_ALUctr,
    output logic [2:0]             out_Branch,
    output logic                   out_MemtoReg,
    output logic                   out_MemWr,
    output logic [2:0]             out_MemOp,
    output logic [3:0]             out_mdu_op,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ctrl_t             dec_ctrl;
    logic [31:0]       dec_imm;
    ctrl_t             ctrl_mem_q [DEPTH];
    logic [31:0]       imm_mem_q  [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;
    ctrl_t             head;

    rv32_decode_core u_core (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    // A push coincident with flush is dropped
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Pointer and occupancy next-state; power-of-two DEPTH wraps naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Pointer/occupancy registers; flush and reset both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until pushed (outputs gated by valid)
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ctrl_mem_q[wr_ptr_q] <= dec_ctrl;
            imm_mem_q[wr_ptr_q]  <= dec_imm;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

    assign head         = out_valid ? ctrl_mem_q[rd_ptr_q] : '0;
    assign out_imm      = out_valid ? imm_mem_q[rd_ptr_q]  : '0;
    assign out_pc       = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign out_ExtOp    = head.ExtOp;
    assign out_RegWr    = head.RegWr;
    assign out_ALUAsrc  = head.ALUAsrc;
    assign out_ALUBsrc  = head.ALUBsrc;
    assign out_ALUctr   = head.ALUctr;
    assign out_Branch   = head.Branch;
    assign out_MemtoReg = head.MemtoReg;
    assign out_MemWr    = head.MemWr;
    assign out_MemOp    = head.MemOp;
    assign out_mdu_op   = head.mdu_op;
    assign out_illegal  = head.illegal;
    assign count        = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived from the RV32I encodings.
module tb_decode_stage;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic                   clk = 1'b0;
    logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]            in_instr, out_imm;
    logic [PC_W-1:0]        in_pc, out_pc;
    logic [2:0]             out_ExtOp, out_Branch, out_MemOp;
    logic                   out_RegWr, out_ALUAsrc, out_MemtoReg, out_MemWr, out_illegal;
    logic [1:0]             out_ALUBsrc;
    logic [3:0]             out_ALUctr, out_mdu_op;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_ExtOp(out_ExtOp), .out_RegWr(out_RegWr), .out_ALUAsrc(out_ALUAsrc),
        .out_ALUBsrc(out_ALUBsrc), .out_ALUctr(out_ALUctr), .out_Branch(out_Branch),
        .out_MemtoReg(out_MemtoReg), .out_MemWr(out_MemWr), .out_MemOp(out_MemOp),
        .out_mdu_op(out_mdu_op), .out_illegal(out_illegal), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Push one instruction across one rising edge (FIFO must not be full)
    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pop the head across one rising edge
    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_oval",   32'(out_valid), 32'd0);
        chk("rst_irdy",   32'(in_ready), 32'd1);
        chk("rst_imm",    out_imm, 32'd0);
        chk("rst_pc",     out_pc, 32'd0);
        chk("rst_regwr",  32'(out_RegWr), 32'd0);

        // addi x1,x0,5: visible right after the push edge
        push(32'h00500093, 32'h100);
        chk("addi_oval",  32'(out_valid), 32'd1);
        chk("addi_alu",   32'(out_ALUctr), 32'b0000);
        chk("addi_bsrc",  32'(out_ALUBsrc), 32'b01);
        chk("addi_regwr", 32'(out_RegWr), 32'd1);
        chk("addi_imm",   out_imm, 32'd5);
        chk("addi_pc",    out_pc, 32'h100);
        chk("addi_cnt",   32'(count), 32'd1);
        pop();
        chk("addi_popped", 32'(out_valid), 32'd0);

        // sub then beq back-to-back, out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h40208033; in_pc = 32'h104;
        @(negedge clk);
        chk("sub_alu",    32'(out_ALUctr), 32'b1000);
        chk("sub_bsrc",   32'(out_ALUBsrc), 32'b00);
        chk("sub_regwr",  32'(out_RegWr), 32'd1);
        in_instr = 32'h FE000EE3; in_pc = 32'h108;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pushpop_cnt", 32'(count), 32'd1);
        chk("beq_br",     32'(out_Branch), 32'b100);
        chk("beq_ext",    32'(out_ExtOp), 32'b011);
        // beq x0,x0,-4: imm[12]=1, imm[11]=instr[7]=1, imm[10:5]=111111, imm[4:1]=1110
        chk("beq_imm",    out_imm, 32'hFFFFFFFC);
        chk("beq_regwr",  32'(out_RegWr), 32'd0);
        chk("beq_pc",     out_pc, 32'h108);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bb_empty",   32'(count), 32'd0);

        // Empty: an out_ready pulse changes nothing
        pop();
        chk("empty_pop_cnt",  32'(count), 32'd0);
        chk("empty_pop_irdy", 32'(in_ready), 32'd1);

        // Fill to DEPTH with addi x1,x0,k
        for (int k = 0; k < DEPTH; k++)
            push(32'h00000093 | (32'(k + 1) << 20), 32'h200 + 32'(4 * k));
        chk("full_irdy", 32'(in_ready), 32'd0);
        chk("full_cnt",  32'(count), 32'(DEPTH));
        // A push attempt while full is refused
        push(32'h07F00093, 32'h300);
        chk("full_hold_cnt", 32'(count), 32'(DEPTH));
        // Drain in order
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain_imm%0d", k), out_imm, 32'(k + 1));
            chk($sformatf("drain_pc%0d", k),  out_pc, 32'h200 + 32'(4 * k));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_irdy", 32'(in_ready), 32'd1);
        chk("drain_cnt",  32'(count), 32'd0);

        // Unlisted opcode -> NOP bundle, illegal
        push(32'h0000307F, 32'h400);
        chk("bad_ill",   32'(out_illegal), 32'd1);
        chk("bad_regwr", 32'(out_RegWr), 32'd0);
        chk("bad_memwr", 32'(out_MemWr), 32'd0);
        chk("bad_br",    32'(out_Branch), 32'd0);
        chk("bad_oval",  32'(out_valid), 32'd1);
        pop();

        // lui x1,0x12345
        push(32'h123450B7, 32'h404);
        chk("lui_ext", 32'(out_ExtOp), 32'b001);
        chk("lui_alu", 32'(out_ALUctr), 32'b1111);
        chk("lui_imm", out_imm, 32'h12345000);
        pop();

        // jal x1,8
        push(32'h008000EF, 32'h408);
        chk("jal_ext",  32'(out_ExtOp), 32'b100);
        chk("jal_br",   32'(out_Branch), 32'b001);
        chk("jal_asrc", 32'(out_ALUAsrc), 32'd1);
        chk("jal_bsrc", 32'(out_ALUBsrc), 32'b10);
        chk("jal_imm",  out_imm, 32'd8);
        pop();

        // lw x1,0(x2)
        push(32'h00012083, 32'h40C);
        chk("lw_m2r",   32'(out_MemtoReg), 32'd1);
        chk("lw_memop", 32'(out_MemOp), 32'b010);
        chk("lw_ill",   32'(out_illegal), 32'd0);
        pop();

        // store with func3=011 is illegal
        push(32'h00113023, 32'h410);
        chk("sd_ill",   32'(out_illegal), 32'd1);
        chk("sd_memwr", 32'(out_MemWr), 32'd0);
        pop();

        // Flush with coincident push
        push(32'h00500093, 32'h500);
        push(32'h00600093, 32'h504);
        chk("pre_flush_cnt", 32'(count), 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h508;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_cnt",  32'(count), 32'd0);
        chk("flush_oval", 32'(out_valid), 32'd0);
        chk("flush_imm",  out_imm, 32'd0);

        // Reset mid-stream behaves like flush
        push(32'h00500093, 32'h600);
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_mid_cnt",  32'(count), 32'd0);
        chk("rst_mid_oval", 32'(out_valid), 32'd0);

        // mul x0,x1,x2
        push(32'h02208033, 32'h700);
`ifdef RV32M_DECODE_EN
        chk("mul_mdu",   32'(out_mdu_op), 32'b1000);
        chk("mul_ill",   32'(out_illegal), 32'd0);
        chk("mul_regwr", 32'(out_RegWr), 32'd1);
`else
        chk("mul_ill",   32'(out_illegal), 32'd1);
        chk("mul_mdu",   32'(out_mdu_op), 32'd0);
`endif
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
